// File: rtl/mmc1_pkg.sv
// Shared constants for the MMC1 mapper: register selects, mirroring modes
// and the reset values of the control and shift registers.
package mmc1_pkg;

    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_CHR0 = 2'd1;
    localparam logic [1:0] REG_CHR1 = 2'd2;
    localparam logic [1:0] REG_PRG  = 2'd3;

    typedef enum logic [1:0] {
        MIRROR_ONE_LOW    = 2'd0,
        MIRROR_ONE_HIGH   = 2'd1,
        MIRROR_VERTICAL   = 2'd2,
        MIRROR_HORIZONTAL = 2'd3
    } mirror_e;

    localparam logic [4:0] CTRL_RESET  = 5'b01100;
    localparam logic [4:0] SHIFT_EMPTY = 5'b10000;

endpackage

// File: rtl/mapper_mmc1_if.sv
// CPU/PPU-side bus of the MMC1 mapper. The master drives CPU and PPU
// addresses; the slave (mapper) returns the translated memory addresses.
interface mapper_mmc1_if #(
    parameter int PRG_WIDTH = 17,
    parameter int CHR_WIDTH = 17
);
    logic [15:0]          prga;
    logic [7:0]           prgd;
    logic                 prgw;
    logic [13:0]          chra;
    logic [PRG_WIDTH-1:0] prg_address;
    logic [CHR_WIDTH-1:0] chr_address;
    logic [10:0]          vrm_address;
    logic                 wram_en;
    logic [4:0]           ctrl;

    modport master (
        output prga, prgd, prgw, chra,
        input  prg_address, chr_address, vrm_address, wram_en, ctrl
    );

    modport slave (
        input  prga, prgd, prgw, chra,
        output prg_address, chr_address, vrm_address, wram_en, ctrl
    );
endinterface

// File: rtl/mmc1_serial.sv
// Serial write port of the MMC1: strobe edge detect and the 5-bit shift
// register; emits a one-clock load (or clear) request with select and value.
module mmc1_serial
    import mmc1_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       prgw,
    input  logic       prga15,
    input  logic [1:0] prga_sel,
    input  logic       reset_bit,
    input  logic       data_bit,
    output logic       load,
    output logic       clear,
    output logic [1:0] sel,
    output logic [4:0] value
);
    logic [4:0] shift_q;
    logic       strobe;
    logic       strobe_q;
    logic       write_evt;

    assign strobe    = prgw & prga15;
    assign write_evt = strobe & ~strobe_q;

    assign value = {data_bit, shift_q[4:1]};
    assign sel   = prga_sel;
    assign load  = write_evt & ~reset_bit & shift_q[0];
    assign clear = write_evt & reset_bit;

    // During reset the edge register tracks the live strobe, so a strobe
    // held high across reset release must fall and rise before it counts.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            shift_q  <= SHIFT_EMPTY;
            strobe_q <= strobe;
        end else begin
            strobe_q <= strobe;
            if (write_evt) begin
                if (reset_bit || shift_q[0]) begin
                    shift_q <= SHIFT_EMPTY;
                end else begin
                    shift_q <= value;
                end
            end
        end
    end

endmodule

// File: rtl/mapper_mmc1.sv
// MMC1 (SxROM) bank mapper: holds ctrl/chr0/chr1/prg and translates CPU,
// PPU pattern and nametable addresses combinationally.
module mapper_mmc1
    import mmc1_pkg::*;
#(
    parameter int PRG_WIDTH = 17,
    parameter int CHR_WIDTH = 17
) (
    input  logic clock,
    input  logic reset_n,
    mapper_mmc1_if.slave bus
);
    localparam int B = PRG_WIDTH - 14;
    localparam logic [B-1:0] LAST = '1;

    logic       load;
    logic       clear;
    logic [1:0] sel;
    logic [4:0] value;
    logic [4:0] ctrl_q;
    logic [4:0] chr0_q;
    logic [4:0] chr1_q;
    logic [4:0] prg_q;
    logic [B-1:0] bank16;
    logic       a10;
    logic       unused;

    mmc1_serial u_serial (
        .clock     (clock),
        .reset_n   (reset_n),
        .prgw      (bus.prgw),
        .prga15    (bus.prga[15]),
        .prga_sel  (bus.prga[14:13]),
        .reset_bit (bus.prgd[7]),
        .data_bit  (bus.prgd[0]),
        .load      (load),
        .clear     (clear),
        .sel       (sel),
        .value     (value)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ctrl_q <= CTRL_RESET;
            chr0_q <= '0;
            chr1_q <= '0;
            prg_q  <= '0;
        end else if (clear) begin
            ctrl_q <= ctrl_q | CTRL_RESET;
        end else if (load) begin
            case (sel)
                REG_CTRL: ctrl_q <= value;
                REG_CHR0: chr0_q <= value;
                REG_CHR1: chr1_q <= value;
                REG_PRG:  prg_q  <= value;
                default:  ctrl_q <= ctrl_q;
            endcase
        end
    end

    // 32K mode reuses the bank register with its low bit replaced by A14.
    always_comb begin
        bank16 = {prg_q[B-1:1], bus.prga[14]};
        case (ctrl_q[3:2])
            2'b10:   bank16 = bus.prga[14] ? prg_q[B-1:0] : '0;
            2'b11:   bank16 = bus.prga[14] ? LAST : prg_q[B-1:0];
            default: bank16 = {prg_q[B-1:1], bus.prga[14]};
        endcase
    end

    always_comb begin
        a10 = 1'b0;
        case (mirror_e'(ctrl_q[1:0]))
            MIRROR_ONE_LOW:    a10 = 1'b0;
            MIRROR_ONE_HIGH:   a10 = 1'b1;
            MIRROR_VERTICAL:   a10 = bus.chra[10];
            MIRROR_HORIZONTAL: a10 = bus.chra[11];
            default:           a10 = 1'b0;
        endcase
    end

    assign bus.prg_address = {bank16, bus.prga[13:0]};
    assign bus.chr_address = ctrl_q[4]
                           ? {(bus.chra[12] ? chr1_q : chr0_q), bus.chra[11:0]}
                           : {chr0_q[4:1], bus.chra[12:0]};
    assign bus.vrm_address = {a10, bus.chra[9:0]};
    assign bus.wram_en     = (bus.prga[15:13] == 3'b011) & ~prg_q[4];
    assign bus.ctrl        = ctrl_q;

    assign unused = ^{bus.prgd, bus.chra[13], prg_q};

endmodule
